pwm_ramp_controller: RTL and testbench

PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

---
 rtl/pwm_ramp_controller_pkg.sv | 18 +
 rtl/ramp_tick_timer.sv | 27 ++
 rtl/pwm_ramp_controller.sv | 144 ++++++++++++++
 tb/tb_pwm_ramp_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_controller_pkg.sv
// Shared definitions for the PWM ramp controller: controller states,
// configuration register addresses and the duty-cycle width.
package pwm_ramp_controller_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_TARGET      = 2'd0;
    localparam logic [1:0] ADDR_STEP        = 2'd1;
    localparam logic [1:0] ADDR_INTERVAL_LO = 2'd2;
    localparam logic [1:0] ADDR_INTERVAL_HI = 2'd3;

endpackage

// File: rtl/ramp_tick_timer.sv
// Loadable down-counter that paces duty updates; zero marks the update cycle.
module ramp_tick_timer #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dec,
    input  logic [TICK_W-1:0] load_val,
    output logic              zero
);

    logic [TICK_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - TICK_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_ramp_controller.sv
// Steps the PWM duty value toward a configured target by STEP every INTERVAL
// cycles, with one-cycle done pulse, abort and a config port open only in IDLE.
module pwm_ramp_controller
    import pwm_ramp_controller_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_addr,
    input  logic [DUTY_W-1:0] cfg_data,
    output logic              cfg_ready,
    input  logic              start,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] duty_q, target_q, step_q, ilo_q, ihi_q;
    logic [DUTY_W-1:0] target_eff, ilo_eff, ihi_eff;
    logic [DUTY_W-1:0] step_use, duty_nxt;
    logic [TICK_W-1:0] interval_use, reload_val;
    logic              cfg_wr, duty_upd, tmr_load, tmr_dec, tmr_zero;

    // 9-bit move toward the target that lands exactly on it instead of overshooting or wrapping.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt,
                                                      input logic [DUTY_W-1:0] stp);
        logic [DUTY_W:0] acc;
        if (cur < tgt) begin
            acc = {1'b0, cur} + {1'b0, stp};
            if (acc >= {1'b0, tgt}) acc = {1'b0, tgt};
        end else begin
            acc = {1'b0, cur} - {1'b0, stp};
            if (acc[DUTY_W] || (acc <= {1'b0, tgt})) acc = {1'b0, tgt};
        end
        return acc[DUTY_W-1:0];
    endfunction

    assign cfg_wr = cfg_valid && (state == ST_IDLE);

    // A write landing together with start must already steer that start decision.
    always_comb begin
        target_eff = target_q;
        ilo_eff    = ilo_q;
        ihi_eff    = ihi_q;
        if (cfg_wr) begin
            case (cfg_addr)
                ADDR_TARGET:      target_eff = cfg_data;
                ADDR_INTERVAL_LO: ilo_eff    = cfg_data;
                ADDR_INTERVAL_HI: ihi_eff    = cfg_data;
                default: ;
            endcase
        end
        interval_use = TICK_W'({ihi_eff, ilo_eff});
        if (interval_use == '0) interval_use = TICK_W'(1);
        reload_val = interval_use - TICK_W'(1);
    end

    assign step_use = (step_q == '0) ? DUTY_W'(1) : step_q;
    assign duty_nxt = step_toward(duty_q, target_q, step_use);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        duty_upd  = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (duty_q == target_eff) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RAMP;
                        tmr_load  = 1'b1;
                    end
                end
            end
            ST_RAMP: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (tmr_zero) begin
                    duty_upd = 1'b1;
                    tmr_load = 1'b1;
                    if (duty_nxt == target_q) state_nxt = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= DUTY_W'(1);
            ilo_q    <= DUTY_W'(1);
            ihi_q    <= '0;
        end else begin
            if (cfg_wr) begin
                case (cfg_addr)
                    ADDR_TARGET:      target_q <= cfg_data;
                    ADDR_STEP:        step_q   <= cfg_data;
                    ADDR_INTERVAL_LO: ilo_q    <= cfg_data;
                    ADDR_INTERVAL_HI: ihi_q    <= cfg_data;
                    default: ;
                endcase
            end
            if (duty_upd) duty_q <= duty_nxt;
        end
    end

    ramp_tick_timer #(
        .TICK_W(TICK_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (reload_val),
        .zero     (tmr_zero)
    );

    assign duty_out  = duty_q;
    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_RAMP);
    // An abort arriving in the DONE cycle cancels the completion pulse.
    assign done      = (state == ST_DONE) && !abort;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Randomized and directed bench for pwm_ramp_controller against a timestamp-based
// behavioural model of the ramp schedule.
module tb_pwm_ramp_controller;

    localparam int TICK_W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cfg_ready;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    pwm_ramp_controller #(.TICK_W(TICK_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .start     (start),
        .abort     (abort),
        .duty_out  (duty_out),
        .busy      (busy),
        .done      (done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: registers plus an absolute edge index at which the next duty update is due.
    int m_duty, m_target, m_step, m_ilo, m_ihi, m_cyc, m_next;
    bit m_ramp, m_done;

    function automatic int eff_interval(int hi, int lo);
        int v;
        v = ((hi << 8) | lo) % (1 << TICK_W);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int toward(int cur, int tgt, int stp);
        int s;
        s = (stp == 0) ? 1 : stp;
        if (cur < tgt) return (cur + s > tgt) ? tgt : cur + s;
        return (cur - s < tgt) ? tgt : cur - s;
    endfunction

    task automatic model_reset();
        m_duty = 0; m_target = 0; m_step = 1; m_ilo = 1; m_ihi = 0;
        m_ramp = 0; m_done = 0; m_cyc = 0; m_next = 0;
    endtask

    task automatic model_edge();
        bit idle, was_ramp, new_done;
        idle     = !m_ramp && !m_done;
        was_ramp = m_ramp;
        new_done = 0;
        if (cfg_valid && idle) begin
            case (cfg_addr)
                2'd0: m_target = int'(cfg_data);
                2'd1: m_step   = int'(cfg_data);
                2'd2: m_ilo    = int'(cfg_data);
                default: m_ihi = int'(cfg_data);
            endcase
        end
        if (idle && start && !abort) begin
            if (m_duty == m_target) begin
                new_done = 1;
            end else begin
                m_ramp = 1;
                m_next = m_cyc + eff_interval(m_ihi, m_ilo);
            end
        end
        if (was_ramp) begin
            if (abort) begin
                m_ramp = 0;
            end else if (m_cyc == m_next) begin
                m_duty = toward(m_duty, m_target, m_step);
                m_next = m_next + eff_interval(m_ihi, m_ilo);
                if (m_duty == m_target) begin
                    m_ramp   = 0;
                    new_done = 1;
                end
            end
        end
        m_done = new_done;
        m_cyc++;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    endtask

    task automatic pin(string nm, int dut_v, int mdl_v, int exp);
        chk(nm, dut_v, exp);
        chk({nm, "_model"}, mdl_v, exp);
    endtask

    // One clock: apply inputs, let the edge happen, then compare at the falling edge.
    task automatic step(int r, int cv, int ca, int cd, int st, int ab);
        rst       = (r != 0);
        cfg_valid = (cv != 0);
        cfg_addr  = 2'(ca);
        cfg_data  = 8'(cd);
        start     = (st != 0);
        abort     = (ab != 0);
        if (r != 0) model_reset();
        @(posedge clk);
        if (r == 0) model_edge();
        @(negedge clk);
        chk("duty",      int'(duty_out),  m_duty);
        chk("busy",      int'(busy),      int'(m_ramp));
        chk("done",      int'(done),      int'(m_done && !abort));
        chk("cfg_ready", int'(cfg_ready), int'(!m_ramp && !m_done));
    endtask

    task automatic idle();             step(0, 0, 0, 0, 0, 0); endtask
    task automatic wr(int a, int d);   step(0, 1, a, d, 0, 0); endtask
    task automatic go();               step(0, 0, 0, 0, 1, 0); endtask
    task automatic do_rst();           step(1, 0, 0, 0, 0, 0); idle(); endtask

    initial begin
        model_reset();
        do_rst();
        pin("rst_duty",  int'(duty_out),  m_duty, 0);
        pin("rst_ready", int'(cfg_ready), int'(!m_ramp && !m_done), 1);

        // 0 -> 200 in steps of 50 every 4 cycles
        wr(0, 200); wr(1, 50); wr(2, 4); wr(3, 0);
        go();
        for (int k = 1; k <= 17; k++) begin
            idle();
            if (k == 4)  pin("A_duty4",  int'(duty_out), m_duty, 50);
            if (k == 8)  pin("A_duty8",  int'(duty_out), m_duty, 100);
            if (k == 12) pin("A_duty12", int'(duty_out), m_duty, 150);
            if (k == 16) begin
                pin("A_duty16", int'(duty_out), m_duty, 200);
                pin("A_done16", int'(done), int'(m_done), 1);
            end
            if (k == 17) pin("A_busy17", int'(busy), int'(m_ramp), 0);
        end

        // 200 -> 10 with a step of 64 clamps at the target
        wr(0, 10); wr(1, 64); wr(2, 1);
        go();
        idle(); pin("B_duty1", int'(duty_out), m_duty, 136);
        idle(); pin("B_duty2", int'(duty_out), m_duty, 72);
        idle(); pin("B_duty3", int'(duty_out), m_duty, 10);
        pin("B_done3", int'(done), int'(m_done), 1);
        idle(); pin("B_done4", int'(done), int'(m_done), 0);

        // target already reached
        go();
        pin("C_done", int'(done), int'(m_done), 1);
        pin("C_busy", int'(busy), int'(m_ramp), 0);
        idle();

        // abort at duty 20; the TARGET write during the ramp is dropped
        do_rst();
        wr(0, 255); wr(2, 3);
        go();
        for (int k = 1; k <= 60; k++) begin
            if (k == 30) wr(0, 0);
            else idle();
        end
        pin("D_duty60", int'(duty_out), m_duty, 20);
        step(0, 0, 0, 0, 0, 1);
        pin("D_abort_busy", int'(busy), int'(m_ramp), 0);
        pin("D_abort_done", int'(done), int'(m_done), 0);
        for (int k = 0; k < 5; k++) idle();
        pin("D_hold", int'(duty_out), m_duty, 20);
        go(); idle(); idle(); idle();
        pin("D_target_kept", int'(duty_out), m_duty, 21);
        step(0, 0, 0, 0, 0, 1);

        // zero STEP and zero INTERVAL behave as one
        do_rst();
        wr(1, 0); wr(2, 0); wr(3, 0); wr(0, 3);
        go();
        idle(); pin("E_duty1", int'(duty_out), m_duty, 1);
        idle(); pin("E_duty2", int'(duty_out), m_duty, 2);
        idle(); pin("E_duty3", int'(duty_out), m_duty, 3);
        pin("E_done", int'(done), int'(m_done), 1);

        // reset in the middle of a ramp
        do_rst();
        wr(0, 200); wr(1, 10); wr(2, 2);
        go();
        for (int k = 0; k < 8; k++) idle();
        pin("F_duty40", int'(duty_out), m_duty, 40);
        step(1, 0, 0, 0, 0, 0);
        pin("F_rst_duty", int'(duty_out), m_duty, 0);
        pin("F_rst_busy", int'(busy), int'(m_ramp), 0);
        for (int k = 0; k < 10; k++) idle();
        pin("F_no_done", int'(done), int'(m_done), 0);

        // write plus start in one cycle, then abort plus start in IDLE
        step(0, 1, 0, 5, 1, 0);
        for (int k = 0; k < 5; k++) idle();
        pin("G_duty5", int'(duty_out), m_duty, 5);
        idle();
        step(0, 0, 0, 0, 1, 1);
        pin("G_abort_start", int'(cfg_ready), int'(!m_ramp && !m_done), 1);

        for (int i = 0; i < 3000; i++) begin
            int r, cv, ca, cd, st, ab;
            r  = ($urandom_range(0, 299) == 0) ? 1 : 0;
            cv = ($urandom_range(0, 99) < 25) ? 1 : 0;
            ca = int'($urandom_range(0, 3));
            if (ca == 2)      cd = int'($urandom_range(0, 6));
            else if (ca == 3) cd = ($urandom_range(0, 19) == 0) ? 1 : 0;
            else              cd = int'($urandom_range(0, 255));
            st = ($urandom_range(0, 99) < 12) ? 1 : 0;
            ab = ($urandom_range(0, 99) < 3) ? 1 : 0;
            step(r, cv, ca, cd, st, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
